// File: rtl/snake_move_ctrl.sv
// Snake body sequencer: owns the segment array and advances it one step per tick.
// Each step runs shift, head move, then border and self-collision checks.
module snake_move_ctrl #(
  parameter int MAX_LEN = 128,
  parameter int STEP    = 10,
  parameter int X_MIN   = 10,
  parameter int X_MAX   = 620,
  parameter int Y_MIN   = 10,
  parameter int Y_MAX   = 460,
  parameter int START_X = 320,
  parameter int START_Y = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [4:0] dir,
  input  logic       grow,
  input  logic [6:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  output logic [6:0] len,
  output logic       busy,
  output logic       step_done,
  output logic       game_over
);

  localparam logic [4:0]  D_UP    = 5'b00010;
  localparam logic [4:0]  D_LEFT  = 5'b00100;
  localparam logic [4:0]  D_DOWN  = 5'b01000;
  localparam logic [4:0]  D_RIGHT = 5'b10000;
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_MIN_W = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
  localparam logic [9:0]  START_X_W = 10'(START_X);
  localparam logic [8:0]  START_Y_W = 9'(START_Y);

  typedef enum logic [2:0] {IDLE, READY, SHIFT, HEAD, CHECK, DEAD} state_t;

  state_t      state;
  logic [9:0]  seg_x [MAX_LEN];
  logic [8:0]  seg_y [MAX_LEN];
  logic [7:0]  len_q;
  logic [6:0]  idx;
  logic [4:0]  cur_dir;
  logic        grow_pend;
  logic [10:0] head_x, head_y;

  logic [4:0]  opp_dir;
  logic        dir_take;
  logic [7:0]  len_next;
  logic [10:0] hx_next, hy_next;
  logic        border_bad, body_hit, last_chk;

  always_comb begin
    case (cur_dir)
      D_UP:    opp_dir = D_DOWN;
      D_DOWN:  opp_dir = D_UP;
      D_LEFT:  opp_dir = D_RIGHT;
      default: opp_dir = D_LEFT;
    endcase
    dir_take = ((dir == D_UP) || (dir == D_LEFT) || (dir == D_DOWN) || (dir == D_RIGHT))
               && (dir != opp_dir);
    len_next = ((grow || grow_pend) && (len_q < LEN_MAX)) ? len_q + 8'd1 : len_q;
  end

  // 11-bit head arithmetic so an underflow past 0 shows up as a huge value and trips the border test
  always_comb begin
    hx_next = {1'b0, seg_x[0]};
    hy_next = {2'b00, seg_y[0]};
    case (cur_dir)
      D_UP:    hy_next = {2'b00, seg_y[0]} - STEP_W;
      D_DOWN:  hy_next = {2'b00, seg_y[0]} + STEP_W;
      D_LEFT:  hx_next = {1'b0, seg_x[0]} - STEP_W;
      default: hx_next = {1'b0, seg_x[0]} + STEP_W;
    endcase
  end

  assign border_bad = (head_x < X_MIN_W) || (head_x > X_MAX_W) ||
                      (head_y < Y_MIN_W) || (head_y > Y_MAX_W);
  assign body_hit   = (len_q > 8'd1) && (seg_x[idx] == seg_x[0]) && (seg_y[idx] == seg_y[0]);
  assign last_chk   = ({1'b0, idx} >= (len_q - 8'd1));

  always_ff @(posedge clk) begin
    if (rst || !start) begin
      state     <= IDLE;
      len_q     <= 8'd1;
      seg_x[0]  <= START_X_W;
      seg_y[0]  <= START_Y_W;
      head_x    <= {1'b0, START_X_W};
      head_y    <= {2'b00, START_Y_W};
      cur_dir   <= D_RIGHT;
      grow_pend <= 1'b0;
      idx       <= 7'd0;
      step_done <= 1'b0;
      game_over <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (grow && (state inside {READY, SHIFT, HEAD, CHECK}))
        grow_pend <= 1'b1;
      case (state)
        IDLE: state <= READY;
        READY: begin
          if (tick) begin
            if (dir_take)
              cur_dir <= dir;
            len_q     <= len_next;
            grow_pend <= 1'b0;
            idx       <= 7'(len_next - 8'd1);
            state     <= (len_next > 8'd1) ? SHIFT : HEAD;
          end
        end
        SHIFT: begin
          seg_x[idx] <= seg_x[idx - 7'd1];
          seg_y[idx] <= seg_y[idx - 7'd1];
          idx        <= idx - 7'd1;
          if (idx == 7'd1)
            state <= HEAD;
        end
        HEAD: begin
          head_x   <= hx_next;
          head_y   <= hy_next;
          seg_x[0] <= hx_next[9:0];
          seg_y[0] <= hy_next[8:0];
          idx      <= 7'd1;
          state    <= CHECK;
        end
        CHECK: begin
          if (border_bad || body_hit) begin
            game_over <= 1'b1;
            state     <= DEAD;
          end else if (last_chk) begin
            step_done <= 1'b1;
            state     <= READY;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        default: state <= DEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x <= 10'h3FF;
      rd_y <= 9'h1FF;
    end else if ({1'b0, rd_idx} < len_q) begin
      rd_x <= seg_x[rd_idx];
      rd_y <= seg_y[rd_idx];
    end else begin
      rd_x <= 10'h3FF;
      rd_y <= 9'h1FF;
    end
  end

  // A full MAX_LEN of 128 does not fit the 7-bit length port and reads back as 0
  assign len  = len_q[6:0];
  assign busy = (state == SHIFT) || (state == HEAD) || (state == CHECK);

endmodule
